eth_measurer_tx: RTL and testbench

ETH_MEASURER_TX -- requirements
Module: eth_measurer_tx

---
 rtl/eth_measurer_tx.sv | 125 ++++++++++++
 tb/tb_eth_measurer_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/eth_measurer_tx.sv
// Ping/measurement frame generator: emits one fixed-layout Ethernet frame (no FCS)
// per accepted trigger over an 8-bit AXI-Stream master.
module eth_measurer_tx #(
  parameter logic [47:0] src_mac    = 48'h00_00_00_00_00_00,
  parameter logic [31:0] identifier = 32'h00000000,
  parameter logic [15:0] ethertype  = 16'h88B5,
  parameter int unsigned frame_len  = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger,
  input  logic [63:0] ping_id,
  output logic        busy,
  output logic [31:0] frames_sent,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);

  localparam int unsigned IDX_W     = 11;
  localparam int unsigned HDR_BYTES = 18;
  localparam int unsigned PING_END  = 26;
  localparam int unsigned HDR_W     = 8 * HDR_BYTES;
  localparam logic [HDR_W-1:0]  HDR      = {48'hFFFF_FFFF_FFFF, src_mac, ethertype, identifier};
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(frame_len - 1);

  if (frame_len < 26 || frame_len > 1514) begin : g_bad_frame_len
    $error("eth_measurer_tx: frame_len must be within 26..1514");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [63:0]      ping_q, ping_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d;

  // Byte at a given frame offset: constant header, then latched ping, then zero pad.
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx, input logic [63:0] ping);
    int unsigned      i;
    logic [HDR_W-1:0] hs;
    logic [63:0]      ps;
    i  = 32'(idx);
    hs = '0;
    ps = '0;
    frame_byte = 8'h00;
    if (i < HDR_BYTES) begin
      hs = HDR << (8 * i);
      frame_byte = hs[HDR_W-1 -: 8];
    end else if (i < PING_END) begin
      ps = ping << (8 * (i - HDR_BYTES));
      frame_byte = ps[63:56];
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ping_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ping_q  <= ping_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // Data and tlast are precomputed for the index being presented, so they hold during stalls.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ping_d  = ping_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = SEND;
          idx_d   = '0;
          ping_d  = ping_id;
          data_d  = frame_byte('0, ping_id);
          last_d  = 1'b0;
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (last_q) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = cnt_q + 32'd1;
            data_d  = 8'h00;
            last_d  = 1'b0;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = frame_byte(idx_d, ping_q);
            last_d = (idx_d == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state_q == SEND);
  assign m_axis_tvalid = busy;
  assign m_axis_tkeep  = busy;
  assign m_axis_tlast  = last_q;
  assign m_axis_tdata  = data_q;
  assign frames_sent   = cnt_q;

endmodule

// File: tb/tb_eth_measurer_tx.sv
// Bench for eth_measurer_tx: two instances (60- and 26-byte frames) against a
// byte-queue reference model with randomized trigger, ping_id and tready.
module tb_eth_measurer_tx;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        trigger = 1'b0;
  logic        tready  = 1'b0;
  logic        preload = 1'b0;
  logic [63:0] ping_id = '0;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_byte(input int i, input logic [63:0] ping, input logic [47:0] mac,
                                          input logic [15:0] et, input logic [31:0] id);
    if (i < 6)  return 8'hFF;
    if (i < 12) return mac[8*(11-i) +: 8];
    if (i < 14) return et[8*(13-i) +: 8];
    if (i < 18) return id[8*(17-i) +: 8];
    if (i < 26) return ping[8*(25-i) +: 8];
    return 8'h00;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int          FL  = (g == 0) ? 60 : 26;
    localparam logic [47:0] MAC = (g == 0) ? 48'h0 : 48'h02_11_22_33_44_55;
    localparam logic [31:0] ID  = (g == 0) ? 32'h0 : 32'hDEADBEEF;

    logic        busy, tvalid, tkeep, tlast;
    logic [7:0]  tdata;
    logic [31:0] fs;

    eth_measurer_tx #(
      .src_mac   (MAC),
      .identifier(ID),
      .ethertype (16'h88B5),
      .frame_len (FL)
    ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .trigger      (trigger),
      .ping_id      (ping_id),
      .busy         (busy),
      .frames_sent  (fs),
      .m_axis_tdata (tdata),
      .m_axis_tkeep (tkeep),
      .m_axis_tlast (tlast),
      .m_axis_tvalid(tvalid),
      .m_axis_tready(tready)
    );

    beat_t       q[$];
    int          rem = 0;
    logic [31:0] cnt = '0;

    // Reference model: a frame is a list of bytes; remaining handshakes decide busy.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        rem = 0;
        cnt = '0;
      end else begin
        if (preload) cnt = '1;
        if (rem > 0) begin
          if (tready) begin
            rem--;
            if (rem == 0) cnt = cnt + 32'd1;
          end
        end else if (trigger) begin
          rem = FL;
          for (int i = 0; i < FL; i++)
            q.push_back(beat_t'{data: ref_byte(i, ping_id, MAC, 16'h88B5, ID), last: (i == FL - 1)});
        end
      end
    end

    // Monitor: compare presented beat with the queue head; pop when the handshake will occur.
    always @(negedge clk) begin
      check($sformatf("g%0d_tvalid", g), 64'(tvalid), 64'(rem > 0));
      check($sformatf("g%0d_busy", g), 64'(busy), 64'(rem > 0));
      check($sformatf("g%0d_tkeep", g), 64'(tkeep), 64'(rem > 0));
      if (!preload) check($sformatf("g%0d_frames_sent", g), 64'(fs), 64'(cnt));
      if (!rst_n) begin
        check($sformatf("g%0d_rst_tdata", g), 64'(tdata), 64'h0);
        check($sformatf("g%0d_rst_tlast", g), 64'(tlast), 64'h0);
      end else if (tvalid) begin
        if (q.size() == 0) begin
          check($sformatf("g%0d_unexpected_beat", g), 64'(tvalid), 64'h0);
        end else begin
          check($sformatf("g%0d_tdata", g), 64'(tdata), 64'(q[0].data));
          check($sformatf("g%0d_tlast", g), 64'(tlast), 64'(q[0].last));
          if (tready) void'(q.pop_front());
        end
      end else begin
        check($sformatf("g%0d_idle_tlast", g), 64'(tlast), 64'h0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(input int budget, input bit rand_ready);
    int k = 0;
    while ((gi[0].rem != 0 || gi[1].rem != 0) && k < budget) begin
      if (rand_ready) tready = 1'($urandom_range(0, 1));
      step(1);
      k++;
    end
    tready = 1'b1;
    check("idle_timeout", 64'(k >= budget), 64'h0);
  endtask

  task automatic send_one(input logic [63:0] pid, input bit rand_ready, input int budget);
    trigger = 1'b1;
    ping_id = pid;
    step(1);
    trigger = 1'b0;
    ping_id = {$urandom, $urandom};
    wait_idle(budget, rand_ready);
    step(1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(gi[0].busy), 64'h0);
    check("rst_tvalid", 64'(gi[0].tvalid), 64'h0);
    check("rst_frames_sent", 64'(gi[0].fs), 64'h0);
    step(2);

    // Trigger on the first edge after reset release.
    rst_n  = 1'b1;
    tready = 1'b1;
    send_one(64'h0123456789ABCDEF, 1'b0, 200);
    check("frame1_count", 64'(gi[0].fs), 64'd1);

    // Random back-pressure.
    send_one(64'h0123456789ABCDEF, 1'b1, 1000);

    // Trigger held high with ping_id changing every cycle.
    trigger = 1'b1;
    for (int c = 0; c < 200; c++) begin
      ping_id = {$urandom, $urandom};
      step(1);
    end
    trigger = 1'b0;
    wait_idle(300, 1'b0);
    step(1);

    // Asynchronous reset mid-frame.
    trigger = 1'b1;
    ping_id = 64'hA5A5_0000_1111_2222;
    step(1);
    trigger = 1'b0;
    step(30);
    rst_n = 1'b0;
    #1;
    check("async_tvalid", 64'(gi[0].tvalid), 64'h0);
    check("async_busy", 64'(gi[0].busy), 64'h0);
    check("async_tlast", 64'(gi[0].tlast), 64'h0);
    check("async_frames_sent", 64'(gi[0].fs), 64'h0);
    step(2);
    rst_n = 1'b1;
    send_one(64'hFEDC_BA98_7654_3210, 1'b1, 1000);
    check("post_rst_count", 64'(gi[0].fs), 64'd1);

    // Counter wrap from all-ones.
    force gi[0].dut.cnt_q = 32'hFFFF_FFFF;
    force gi[1].dut.cnt_q = 32'hFFFF_FFFF;
    preload = 1'b1;
    step(1);
    release gi[0].dut.cnt_q;
    release gi[1].dut.cnt_q;
    preload = 1'b0;
    step(1);
    check("preload_count", 64'(gi[0].fs), 64'hFFFF_FFFF);
    send_one({$urandom, $urandom}, 1'b0, 200);
    check("wrap_count", 64'(gi[0].fs), 64'h0);

    // Random frames with random gaps.
    for (int f = 0; f < 6; f++) begin
      step(int'($urandom_range(0, 3)));
      send_one({$urandom, $urandom}, 1'b1, 1000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
